// File: rtl/scan_pkg.sv
// Types and default sizes shared by the scan-inject controller and the
// scan-dump receive path.
package scan_pkg;

    // Receive-side dump sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Default packing width and buffer depth agreed with the inject side
    localparam int SCAN_WORD_W = 8;
    localparam int SCAN_DEPTH  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is always visible on head_o.
// When the FIFO is empty, head_o keeps the last word handed out.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are qualified by count_q so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/scan_dump_rx.sv
// Receive end of the serial scan-chain dump. Bits arrive LSB-first and are
// packed into WORD_W-bit words, buffered in a small FIFO and handed to the
// host over valid/ready. A trailing partial word is zero-padded and flushed.
module scan_dump_rx
    import scan_pkg::*;
#(
    parameter int WORD_W = SCAN_WORD_W,
    parameter int DEPTH  = SCAN_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ch_out,
    input  logic              ch_out_vld,
    input  logic              ch_out_done,
    output logic [WORD_W-1:0] word_data,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic [CNT_W-1:0]  bit_count,
    output logic              dump_done,
    output logic              overflow,
    output logic              busy
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    scan_state_t       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              take;
    logic [WORD_W-1:0] base_sh;
    logic [IW-1:0]     base_idx;
    logic [WORD_W-1:0] word_next;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // State, packing and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: sample the bit first, then act on end-of-dump
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        base_sh   = shreg_q;
        base_idx  = idx_q;
        word_next = '0;
        push      = 1'b0;
        push_word = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // A valid bit here opens a new dump and is its bit 0
                if (ch_out_vld) begin
                    take     = 1'b1;
                    base_sh  = '0;
                    base_idx = '0;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ch_out_vld) begin
                    take  = 1'b1;
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_FLUSH: begin
                // Unfilled upper bits are already zero in the shift register
                push      = 1'b1;
                push_word = shreg_q;
                shreg_d   = '0;
                idx_d     = '0;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            word_next = base_sh | (WORD_W'(ch_out) << base_idx);
            if (base_idx == LAST_IDX) begin
                push      = 1'b1;
                push_word = word_next;
                shreg_d   = '0;
                idx_d     = '0;
            end else begin
                shreg_d = word_next;
                idx_d   = base_idx + 1'b1;
            end
        end

        // A bit that completes a word alongside done skips the flush
        if (state_q == ST_SHIFT && ch_out_done) begin
            state_d = (idx_d != '0) ? ST_FLUSH : ST_DONE;
        end
    end

    // Sticky overflow: a completed word arrived with nowhere to go
    always_comb begin
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    assign pop       = word_vld & word_rdy;
    assign word_vld  = ~fifo_empty;
    assign bit_count = cnt_q;
    assign overflow  = ovf_q;
    assign dump_done = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .head_o      (word_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_scan_dump_rx.sv
// Scoreboard bench for scan_dump_rx: stimulus pushes expected words, a
// monitor pops and compares whenever a word is handed out.
module tb_scan_dump_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch_out;
    logic        ch_out_vld;
    logic        ch_out_done;
    logic [7:0]  word_data;
    logic        word_vld;
    logic        word_rdy;
    logic [15:0] bit_count;
    logic        dump_done;
    logic        overflow;
    logic        busy;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    scan_dump_rx dut (
        .clk         (clk),
        .rst         (rst),
        .ch_out      (ch_out),
        .ch_out_vld  (ch_out_vld),
        .ch_out_done (ch_out_done),
        .word_data   (word_data),
        .word_vld    (word_vld),
        .word_rdy    (word_rdy),
        .bit_count   (bit_count),
        .dump_done   (dump_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns #1 after the rising edge
    task automatic cyc(input logic v, input logic b, input logic d);
        ch_out_vld  = v;
        ch_out      = b;
        ch_out_done = d;
        @(posedge clk);
        #1;
        ch_out_vld  = 1'b0;
        ch_out      = 1'b0;
        ch_out_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] val, input logic last_done, input logic expect_it);
        if (expect_it) exp_q.push_back(val);
        for (int i = 0; i < 8; i++) cyc(1'b1, val[i], last_done && (i == 7));
    endtask

    initial begin
        logic [10:0] v11;
        logic [7:0]  v5;

        rst         = 1'b1;
        ch_out      = 1'b0;
        ch_out_vld  = 1'b0;
        ch_out_done = 1'b0;
        word_rdy    = 1'b0;

        fork
            forever begin
                logic [7:0] e;
                @(negedge clk);
                if (word_vld && word_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_run++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%0h required no word", word_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", word_data, e);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_word_vld", word_vld, 0);
        check("rst_word_data", word_data, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(1);

        // 0xA5C3, done on last bit: direct to DONE
        word_rdy = 1'b1;
        send_byte(8'hC3, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b1);
        check("a_dump_done", dump_done, 1);
        check("a_bit_count", bit_count, 16);
        check("a_busy", busy, 0);
        idle(1);
        check("a_no_flush_busy", busy, 0);
        check("a_no_flush_done", dump_done, 1);
        idle(3);
        check("a_drained", exp_q.size(), 0);

        // 11 bits then done: partial word flushed zero-padded
        v11 = 11'b101_11001110;
        exp_q.push_back(8'hCE);
        exp_q.push_back(8'h05);
        for (int i = 0; i < 11; i++) cyc(1'b1, v11[i], 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("b_flush_busy", busy, 1);
        check("b_flush_done", dump_done, 0);
        idle(1);
        check("b_dump_done", dump_done, 1);
        check("b_bit_count", bit_count, 11);
        check("b_busy", busy, 0);
        idle(3);
        check("b_drained", exp_q.size(), 0);

        // Back-to-back dumps
        send_byte(8'hFF, 1'b1, 1'b1);
        check("c_done1", dump_done, 1);
        check("c_count1", bit_count, 8);
        exp_q.push_back(8'h01);
        cyc(1'b1, 1'b1, 1'b0);
        check("c_done_drop", dump_done, 0);
        check("c_count_restart", bit_count, 1);
        check("c_busy", busy, 1);
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, i == 7);
        idle(3);
        check("c_drained", exp_q.size(), 0);
        check("c_count2", bit_count, 8);

        // FIFO full, pop coincides with fifth push
        word_rdy = 1'b0;
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b1);
        send_byte(8'h03, 1'b0, 1'b1);
        send_byte(8'h04, 1'b0, 1'b1);
        check("d_vld_full", word_vld, 1);
        check("d_head", word_data, 8'h01);
        v5 = 8'h05;
        exp_q.push_back(v5);
        for (int i = 0; i < 7; i++) cyc(1'b1, v5[i], 1'b0);
        word_rdy = 1'b1;
        cyc(1'b1, v5[7], 1'b1);
        check("d_no_overflow", overflow, 0);
        idle(8);
        check("d_drained", exp_q.size(), 0);
        check("d_no_overflow_end", overflow, 0);
        check("d_vld_empty", word_vld, 0);

        // Async reset mid-dump
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
        check("e_busy_pre", busy, 1);
        check("e_count_pre", bit_count, 5);
        rst = 1'b1;
        #1;
        check("e_rst_count", bit_count, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", dump_done, 0);
        check("e_rst_vld", word_vld, 0);
        check("e_rst_data", word_data, 0);
        check("e_rst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h3C, 1'b1, 1'b1);
        idle(3);
        check("e_drained", exp_q.size(), 0);
        check("e_count", bit_count, 8);
        check("e_done", dump_done, 1);

        // Overflow: six words into a four-deep FIFO with no consumer
        word_rdy = 1'b0;
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'h44, 1'b0, 1'b1);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        check("f_overflow", overflow, 1);
        check("f_count", bit_count, 48);
        check("f_head", word_data, 8'h11);
        word_rdy = 1'b1;
        idle(8);
        check("f_drained", exp_q.size(), 0);
        check("f_vld_empty", word_vld, 0);
        check("f_overflow_sticky", overflow, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_dump_rx.md
Name: scan_dump_rx

Overview:
- Receive end of the serial scan-chain dump stream (ch_out / ch_out_vld / ch_out_done) produced by the scan-inject controller.
- Deserialize chain bits LSB-first into WORD_W-bit words and buffer them in a small FIFO.
- Present words on a valid/ready interface for host readout; report total bit count, completion and overflow status.

Parameters:
- WORD_W, 8, bits per packed output word.
- DEPTH, 4, FIFO depth in words; power of 2, >= 2.
- CNT_W, 16, width of the dump bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_out  in  1  serial chain data bit.
- ch_out_vld  in  1  ch_out valid this cycle.
- ch_out_done  in  1  single-cycle pulse marking end of dump.
- word_data  out  WORD_W  FIFO head word.
- word_vld  out  1  FIFO non-empty.
- word_rdy  in  1  consumer accepts word_data when word_vld && word_rdy.
- bit_count  out  CNT_W  bits received in the current dump.
- dump_done  out  1  level; current dump fully received and flushed.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- busy  out  1  state != IDLE && state != DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; shift register, bit index, FIFO pointers/count cleared; word_data=0, word_vld=0, bit_count=0, dump_done=0, overflow=0, busy=0.
- Reset mid-dump: partial word and buffered words discarded; the rest of that dump is not recovered.
- States:
  - IDLE: first ch_out_vld -> SHIFT.
  - SHIFT: ch_out_done -> FLUSH if bit index != 0, else DONE.
  - FLUSH: one cycle; pushes the partial word -> DONE.
  - DONE: dump_done=1; next ch_out_vld -> SHIFT.
- Entering SHIFT from IDLE or DONE: clear bit_count and dump_done; the triggering bit counts as bit 0 of the new dump.
- Packing:
  - Each sampled valid bit goes to position bit_idx of the current word (LSB-first).
  - bit_idx wraps WORD_W-1 -> 0.
  - The bit filling position WORD_W-1 pushes the completed word (including that bit) into the FIFO on the same edge.
- Latency: word_vld is high in the cycle after the edge that sampled the completing bit, provided the FIFO was empty.
- Flush: partial word has unfilled upper bits = 0; pushed on the FLUSH edge.
- ch_out_vld and ch_out_done in the same cycle: the bit is sampled and counted first, then done is processed. If that bit completes a word, the word is pushed and the FSM goes directly to DONE (no FLUSH).
- ch_out_vld outside SHIFT (in IDLE/DONE) starts a new dump as above. ch_out_done in IDLE/DONE is ignored.
- FIFO:
  - Show-ahead; word_data = head entry. When empty, word_data holds the last value.
  - Pop on word_vld && word_rdy.
  - Push and pop in the same cycle are both performed, including when full; no overflow in that case.
  - Push when full with no pop: word dropped, overflow set. overflow clears only on rst.
- bit_count: increments per sampled valid bit and saturates at 2^CNT_W-1.

Decomposition:
- Shared package scan_pkg: state enum (IDLE, SHIFT, FLUSH, DONE) and the default WORD_W/DEPTH constants shared with the scan-inject controller.
- One sub-module: sync_fifo (parameterized WIDTH, DEPTH; push/pop/full/empty/count, show-ahead). Instantiated once.

Test Plan:
- 16 bits of 0xA5C3 LSB-first, ch_out_done with the last bit, word_rdy=1 -> words 0xC3 then 0xA5; bit_count=16; dump_done=1 the cycle after done; no FLUSH state entered.
- 11 bits 0b101_11001110, then done one cycle later -> words 0xCE and 0x05 (zero-padded via FLUSH); bit_count=11.
- word_rdy=0, 48 bits (6 words) with DEPTH=4 -> first 4 words retained in order; overflow=1; then word_rdy=1 drains exactly those 4 words.
- FIFO full, word_rdy=1 in the exact cycle a 5th word completes -> no overflow; all 5 words read in order.
- rst pulsed after 5 bits of a dump -> all outputs 0 immediately (async); a new 8-bit dump 0x3C afterwards yields exactly one word 0x3C.
- Two back-to-back dumps (8 bits 0xFF, done; then 8 bits 0x01, done) -> dump_done drops on the first bit of dump 2; bit_count restarts at 1; words 0xFF, 0x01.
